// File: rtl/pwm_capture_if.sv
// Measurement-side bundle of pwm_capture: enable/pwm_in toward the block, results back.
// Pure wiring, zero latency; no backpressure (results are pulse/level, no ready).
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             stuck;

    modport master (
        output enable, pwm_in,
        input  period_out, high_out, valid, stuck
    );

    modport slave (
        input  enable, pwm_in,
        output period_out, high_out, valid, stuck
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles; optional glitch filter via PWM_CAP_FILTER_EN.
// Latency: rise detected 3 clk after pwm_in edge (+FILT_LEN-1 with filter); valid registered one cycle later.
// No backpressure: valid is a one-cycle pulse, results hold until the next report.
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_capture_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (FILT_LEN < 1) begin : g_filt_len_chk
        $error("FILT_LEN must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, s_q, s_prev_q;
    logic [CNT_W-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic             valid_q, valid_d, stuck_q, stuck_d;
    logic             rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= bus.pwm_in;
            sync2_q  <= sync1_q;
            s_prev_q <= s_q;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] flt_cnt_q;

    // s flips only once FILT_LEN consecutive synchronised samples disagree with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            flt_cnt_q <= '0;
        end else if (sync2_q != s_q) begin
            if (flt_cnt_q == FW'(FILT_LEN - 1)) begin
                s_q       <= sync2_q;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end else begin
            flt_cnt_q <= '0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= sync2_q;
        end
    end
`endif

    assign rise = s_q & ~s_prev_q;
    assign fall = ~s_q & s_prev_q;

    always_comb begin
        state_d  = state_q;
        cnt_p_d  = cnt_p_q;
        cnt_h_d  = cnt_h_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_p_d = '0;
            cnt_h_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_p_d = '0;
                    cnt_h_d = '0;
                    if (rise) begin
                        state_d = HIGH;
                        cnt_p_d = CNT_ONE;
                        cnt_h_d = CNT_ONE;
                        stuck_d = 1'b0;
                    end
                end
                HIGH, LOW: begin
                    if (state_q == LOW && rise) begin
                        state_d  = HIGH;
                        period_d = cnt_p_q;
                        high_d   = cnt_h_q;
                        valid_d  = 1'b1;
                        cnt_p_d  = CNT_ONE;
                        cnt_h_d  = CNT_ONE;
                    end else if (cnt_p_q == CNT_MAX) begin
                        // counter would wrap: report saturated values and wait for a fresh rise
                        state_d  = IDLE;
                        period_d = CNT_MAX;
                        high_d   = s_q ? CNT_MAX : '0;
                        valid_d  = 1'b1;
                        stuck_d  = 1'b1;
                        cnt_p_d  = '0;
                        cnt_h_d  = '0;
                    end else begin
                        cnt_p_d = cnt_p_q + CNT_ONE;
                        if (state_q == HIGH) begin
                            if (fall) begin
                                state_d = LOW;
                            end else begin
                                cnt_h_d = cnt_h_q + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_p_d = '0;
                    cnt_h_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_p_q  <= '0;
            cnt_h_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_p_q  <= cnt_p_d;
            cnt_h_q  <= cnt_h_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign bus.period_out = period_q;
    assign bus.high_out   = high_q;
    assign bus.valid      = valid_q;
    assign bus.stuck      = stuck_q;
endmodule
